// File: rtl/aes_display_feeder.sv
// Holds one 128-bit AES result for Segment_Control and generates its scan and page clocks.
// Define RESTART_ON_LOAD_EN to restart the page divider and page index on every load.
module aes_display_feeder #(
    parameter int unsigned SCAN_HALF     = 50000,
    parameter int unsigned PAGE_HALF     = 250000000,
    parameter int unsigned MIN_ROTATIONS = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [127:0] in_data,
    output logic         in_ready,
    output logic [127:0] data_out,
    output logic         clk_1khz,
    output logic         clk_5sec,
    output logic [1:0]   page,
    output logic         busy
);

    localparam int unsigned SCAN_W = (SCAN_HALF > 1) ? $clog2(SCAN_HALF) : 1;
    localparam int unsigned PAGE_W = (PAGE_HALF > 1) ? $clog2(PAGE_HALF) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST  = SCAN_W'(SCAN_HALF - 1);
    localparam logic [PAGE_W-1:0] PAGE_LAST  = PAGE_W'(PAGE_HALF - 1);
    localparam logic [5:0]        ROT_TARGET = 6'(4 * MIN_ROTATIONS);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_LOCKED,
        S_OPEN
    } state_t;

    state_t              state_q;
    logic [127:0]        data_q;
    logic [5:0]          rot_cnt_q;
    logic                busy_q;
    logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
    logic                clk_1khz_q, clk_1khz_d;
    logic [PAGE_W-1:0]   page_cnt_q, page_cnt_d;
    logic                clk_5sec_q, clk_5sec_d;
    logic [1:0]          page_q, page_d;
    logic                page_rise;
    logic                transfer;

    assign in_ready  = (state_q != S_LOCKED) && !rst;
    assign transfer  = in_valid && in_ready;
    assign page_rise = (page_cnt_q == PAGE_LAST) && !clk_5sec_q;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        scan_cnt_d = scan_cnt_q + 1'b1;
        clk_1khz_d = clk_1khz_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            clk_1khz_d = ~clk_1khz_q;
        end

        page_cnt_d = page_cnt_q + 1'b1;
        clk_5sec_d = clk_5sec_q;
        if (page_cnt_q == PAGE_LAST) begin
            page_cnt_d = '0;
            clk_5sec_d = ~clk_5sec_q;
        end
        page_d = page_rise ? page_q + 2'd1 : page_q;
`ifdef RESTART_ON_LOAD_EN
        if (transfer) begin
            page_cnt_d = '0;
            clk_5sec_d = 1'b0;
            page_d     = '0;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt_q <= '0;
            clk_1khz_q <= 1'b0;
            page_cnt_q <= '0;
            clk_5sec_q <= 1'b0;
            page_q     <= '0;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            clk_1khz_q <= clk_1khz_d;
            page_cnt_q <= page_cnt_d;
            clk_5sec_q <= clk_5sec_d;
            page_q     <= page_d;
        end
    end

    // A page rise on the load edge is dropped: Segment_Control may have latched the old word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_EMPTY;
            data_q    <= '0;
            rot_cnt_q <= '0;
            busy_q    <= 1'b0;
        end else if (transfer) begin
            state_q   <= S_LOCKED;
            data_q    <= in_data;
            rot_cnt_q <= '0;
            busy_q    <= 1'b1;
        end else if (state_q == S_LOCKED && page_rise) begin
            rot_cnt_q <= rot_cnt_q + 6'd1;
            if (rot_cnt_q + 6'd1 == ROT_TARGET) begin
                state_q <= S_OPEN;
                busy_q  <= 1'b0;
            end
        end
    end

    assign data_out = data_q;
    assign clk_1khz = clk_1khz_q;
    assign clk_5sec = clk_5sec_q;
    assign page     = page_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_aes_display_feeder.sv
// Self-checking bench for aes_display_feeder with an arithmetic reference model of the
// dividers and display-hold rules; honours RESTART_ON_LOAD_EN when defined.
module tb_aes_display_feeder;

    localparam int SH = 4;
    localparam int PH = 10;
    localparam int MR = 1;

    logic         clk      = 1'b0;
    logic         rst      = 1'b1;
    logic         in_valid = 1'b0;
    logic [127:0] in_data  = '0;
    logic         in_ready;
    logic [127:0] data_out;
    logic         clk_1khz;
    logic         clk_5sec;
    logic [1:0]   page;
    logic         busy;

    aes_display_feeder #(.SCAN_HALF(SH), .PAGE_HALF(PH), .MIN_ROTATIONS(MR)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .data_out (data_out),
        .clk_1khz (clk_1khz),
        .clk_5sec (clk_5sec),
        .page     (page),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: edge counts since reset (scan) and since the page origin.
    int           k_scan;
    int           k_page;
    int           m_rises;
    int           m_cnt;
    bit           m_locked;
    logic [127:0] m_data;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        k_scan   = 0;
        k_page   = 0;
        m_rises  = 0;
        m_cnt    = 0;
        m_locked = 1'b0;
        m_data   = '0;
    endtask

    task automatic check_outputs(input string where);
        check({where, ".in_ready"}, 128'(in_ready), 128'(!m_locked && !rst));
        check({where, ".busy"},     128'(busy),     128'(m_locked));
        check({where, ".data_out"}, data_out,       m_data);
        check({where, ".clk_1khz"}, 128'(clk_1khz), 128'((k_scan / SH) % 2));
        check({where, ".clk_5sec"}, 128'(clk_5sec), 128'((k_page / PH) % 2));
        check({where, ".page"},     128'(page),     128'(m_rises % 4));
    endtask

    // One clock: drive inputs, advance the model across the edge, compare #1 later.
    task automatic step(input bit v, input logic [127:0] d, input string where);
        bit xfer;
        bit rise;
        int nxt;
        in_valid = v;
        in_data  = d;
        xfer     = v && !m_locked;
        @(posedge clk);
        k_scan++;
        nxt  = k_page + 1;
        rise = (nxt % (2 * PH)) == PH;
`ifdef RESTART_ON_LOAD_EN
        if (xfer) begin
            k_page  = 0;
            m_rises = 0;
            rise    = 1'b0;
        end else begin
            k_page = nxt;
            if (rise) m_rises++;
        end
`else
        k_page = nxt;
        if (rise) m_rises++;
`endif
        if (xfer) begin
            m_data   = d;
            m_locked = 1'b1;
            m_cnt    = 0;
        end else if (m_locked && rise) begin
            m_cnt++;
            if (m_cnt == 4 * MR) m_locked = 1'b0;
        end
        #1;
        check_outputs(where);
    endtask

    // Edges from a load (page phase kl) until the 4*MR-th later page rise.
    function automatic int lock_len(input int kl);
        int r = kl + 1;
        while ((r % (2 * PH)) != PH) r++;
        return r + (4 * MR - 1) * 2 * PH - kl;
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("rst_now");
        repeat (2) @(posedge clk);
        #1;
        check_outputs("rst_hold");
        rst = 1'b0;
    endtask

    localparam logic [127:0] D1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] D2 = 128'hCAFEBABE_DEADBEEF_01234567_89ABCDEF;
    localparam logic [127:0] D3 = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;

    initial begin
        int f1;
        int f5;
        int npg;
        int cnt;
        int exp_len;
        logic p5;
        int pages [5];
        int exp_pg [5];
        exp_pg = '{1, 2, 3, 0, 1};

        // Power-on reset and release timing, then page sequence over five rises.
        model_reset();
        @(posedge clk);
        #1;
        apply_reset();
        f1 = -1; f5 = -1; npg = 0; p5 = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            step(1'b0, '0, "idle");
            if (clk_1khz && f1 < 0) f1 = i;
            if (clk_5sec && !p5) begin
                if (f5 < 0) f5 = i;
                if (npg < 5) pages[npg] = page;
                npg++;
            end
            p5 = clk_5sec;
        end
        check("scan_first_rise", 128'(f1), 128'(SH));
        check("page_first_rise", 128'(f5), 128'(PH));
        check("page_rise_count", 128'(npg), 128'(5));
        for (int i = 0; i < 5; i++) check("page_seq", 128'(pages[i]), 128'(exp_pg[i]));

        // Single load from EMPTY.
        step(1'b1, D1, "load1");
        check("load1_data", data_out, D1);
        check("load1_busy", 128'(busy), 128'(1));
        check("load1_ready", 128'(in_ready), 128'(0));

        // Second result held from the next cycle: accepted only after four counted rises.
        exp_len = lock_len(k_page);
        cnt = 0;
        while (!in_ready && cnt < 300) begin
            step(1'b1, D2, "hold");
            cnt++;
            if (!in_ready) check("hold_data_kept", data_out, D1);
        end
        check("hold_lock_len", 128'(cnt), 128'(exp_len));
        step(1'b1, D2, "hold_accept");
        check("hold_accept_data", data_out, D2);

        // Wait for OPEN, then load exactly on a page-rise edge.
        cnt = 0;
        while (m_locked && cnt < 300) begin
            step(1'b0, '0, "drain");
            cnt++;
        end
        check("drain_open", 128'(in_ready), 128'(1));
        cnt = 0;
        while (((k_page + 1) % (2 * PH)) != PH && cnt < 40) begin
            step(1'b0, '0, "align");
            cnt++;
        end
        step(1'b1, D3, "coinc_load");
        check("coinc_data", data_out, D3);
        cnt = 0;
        while (!in_ready && cnt < 300) begin
            step(1'b0, '0, "coinc_wait");
            cnt++;
        end
`ifdef RESTART_ON_LOAD_EN
        check("coinc_lock_len", 128'(cnt), 128'(PH + 3 * 2 * PH));
`else
        check("coinc_lock_len", 128'(cnt), 128'(4 * 2 * PH));
`endif

        // Mid-run reset while LOCKED.
        step(1'b1, D1, "pre_rst_load");
        repeat (7) step(1'b0, '0, "pre_rst");
        apply_reset();
        f1 = -1; f5 = -1;
        for (int i = 1; i <= 12; i++) begin
            step(1'b0, '0, "post_rst");
            if (clk_1khz && f1 < 0) f1 = i;
            if (clk_5sec && f5 < 0) f5 = i;
        end
        check("rst_scan_first", 128'(f1), 128'(SH));
        check("rst_page_first", 128'(f5), 128'(PH));

`ifdef RESTART_ON_LOAD_EN
        // Load at an arbitrary divider phase restarts the page clock.
        repeat ($urandom_range(1, 17)) step(1'b0, '0, "rl_idle");
        step(1'b1, D2, "rl_load");
        check("rl_clk5", 128'(clk_5sec), 128'(0));
        check("rl_page", 128'(page), 128'(0));
        f5 = -1;
        for (int i = 1; i <= 2 * PH; i++) begin
            step(1'b0, '0, "rl_run");
            if (clk_5sec && f5 < 0) f5 = i;
        end
        check("rl_first_rise", 128'(f5), 128'(PH));
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom % 4) == 0, {$urandom, $urandom, $urandom, $urandom}, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
